operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode/operand-fetch pipeline stage directly upstream of register_file.
- Accepts 20-bit instructions via valid/ready and drives the register-file read selects. Captures the read data into an ID/EX output register for the execute stage.
- Keeps a 16-entry busy scoreboard so no instruction issues while a source or destination register has a pending write. Writeback clears busy bits and is bypassed into the operands.

Parameters:
- DATA_W, 20, data/instruction width.
- SEL_W, 4, register select width.
- REG_COUNT, 16, number of registers (2**SEL_W).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  20  instruction: [19:16] opcode, [15:12] rd, [11:8] rs1, [7:4] rs2, [7:0] imm8.
- rf_r1_select  out  4  register_file read port 1 select; equals in_instr[11:8], combinational.
- rf_r2_select  out  4  register_file read port 2 select; equals in_instr[7:4], combinational.
- rf_read1  in  20  register_file read data 1; combinational w.r.t. its select.
- rf_read2  in  20  register_file read data 2.
- wb_en  in  1  writeback this cycle; same signal drives register_file w.
- wb_select  in  4  writeback register.
- wb_data  in  20  writeback data.
- flush  in  1  squash the output register.
- out_valid  out  1  ID/EX entry valid.
- out_ready  in  1  execute stage consumes the entry.
- out_opcode  out  4  latched opcode.
- out_rd  out  4  latched destination.
- out_writes_rd  out  1  latched "writes rd" flag.
- out_op1  out  20  operand 1.
- out_op2  out  20  operand 2.
- out_imm  out  20  imm8 sign-extended to 20 bits.
- busy_mask  out  16  scoreboard, bit i = write to register i pending.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, busy_mask=0, and all out_* data fields=0. in_ready follows the combinational rule below; it is 0 while reset is asserted.
- Decode, combinational on in_instr:
  - writes_rd = opcode <= 4'hB.
  - uses_rs2 = opcode <= 4'h7, or opcode is 4'hC or 4'hD.
  - uses_rs1 = opcode != 4'hF.
- Effective busy: eff_busy[i] = busy[i] & ~(wb_en & wb_select==i).
- Stall when any of these holds:
  - uses_rs1 and eff_busy[rs1];
  - uses_rs2 and eff_busy[rs2];
  - writes_rd and eff_busy[rd].
- This blocks RAW and WAW hazards, so at most one pending write exists per register.
- in_ready = reset & ~flush & ~stall & (~out_valid | out_ready).
- Issue = in_valid & in_ready. On issue, the output register loads at the next posedge with 1-cycle latency; out_valid=1.
- Operand bypass: op1 = (wb_en & wb_select==rs1) ? wb_data : rf_read1. op2 uses the same rule with rs2. Unused operands are still latched as read.
- Scoreboard update per posedge:
  - Clear busy[wb_select] if wb_en.
  - Set busy[rd] on an issue with writes_rd.
  - Set and clear on the same register in the same cycle: set wins.
  - A wb_en to a non-busy register is legal; the bit stays 0.
- Output handshake:
  - If out_valid & out_ready and there is no issue, out_valid goes to 0.
  - Output fields hold while out_valid & ~out_ready.
  - Simultaneous consume and issue replaces the entry back-to-back with no bubble.
- Flush:
  - Next edge, out_valid=0.
  - If the squashed entry had out_valid & out_writes_rd, busy[out_rd] is cleared.
  - No issue occurs in a flush cycle.
  - A wb_en in the same cycle still applies.
- Reset mid-operation: the entry and scoreboard are discarded immediately. No output glitch beyond the asynchronous clear.

Test Plan:
- Reset asserted (0) mid-stream with out_valid=1 and busy_mask=16'h0006 -> out_valid=0 and busy_mask=0 immediately. After release, in_ready=1 with out_valid=0.
- Register file preloaded r1=1234, r2=12345; issue opcode 0, rd=3, rs1=1, rs2=2 -> next cycle:
  - out_valid=1, out_op1=1234, out_op2=12345;
  - busy_mask=16'h0008, out_writes_rd=1.
- Next instruction reads r3 while busy[3]=1 -> in_ready=0 for every cycle with out_ready=1. When wb_en=1, wb_select=3, wb_data=111: issue happens that cycle, out_op1=111 (bypass), and busy[3] is set only if the new instruction writes r3.
- Opcode 4'hC with imm8=8'hF0 -> out_imm=20'hFFFF0 and out_writes_rd=0. busy_mask is unchanged.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> out fields are stable and in_ready=0. Then out_ready=1 -> consume and next issue happen in the same edge, and out_valid stays 1.
- Flush with out_valid=1, out_rd=5, out_writes_rd=1 -> out_valid=0 and busy[5]=0 next cycle. in_ready=0 during the flush cycle.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: busy scoreboard, writeback bypass, ID/EX output register.
// Latency 1 cycle issue->out_valid; stalls upstream on hazards, a full un-consumed entry, or flush.
module operand_fetch_stage #(
    parameter int DATA_W    = 20,
    parameter int SEL_W     = 4,
    parameter int REG_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_instr,
    output logic [SEL_W-1:0]     rf_r1_select,
    output logic [SEL_W-1:0]     rf_r2_select,
    input  logic [DATA_W-1:0]    rf_read1,
    input  logic [DATA_W-1:0]    rf_read2,
    input  logic                 wb_en,
    input  logic [SEL_W-1:0]     wb_select,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_opcode,
    output logic [SEL_W-1:0]     out_rd,
    output logic                 out_writes_rd,
    output logic [DATA_W-1:0]    out_op1,
    output logic [DATA_W-1:0]    out_op2,
    output logic [DATA_W-1:0]    out_imm,
    output logic [REG_COUNT-1:0] busy_mask
);

    logic [3:0]       opcode;
    logic [SEL_W-1:0] rd, rs1, rs2;
    logic [7:0]       imm8;
    logic             writes_rd, uses_rs1, uses_rs2;

    assign opcode = in_instr[19:16];
    assign rd     = in_instr[15:12];
    assign rs1    = in_instr[11:8];
    assign rs2    = in_instr[7:4];
    assign imm8   = in_instr[7:0];

    assign writes_rd = (opcode <= 4'hB);
    assign uses_rs2  = (opcode <= 4'h7) || (opcode == 4'hC) || (opcode == 4'hD);
    assign uses_rs1  = (opcode != 4'hF);

    assign rf_r1_select = rs1;
    assign rf_r2_select = rs2;

    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic [REG_COUNT-1:0] wb_hit, eff_busy, flush_clr, issue_set;
    logic                 out_valid_q, out_valid_d;
    logic [3:0]           out_opcode_q;
    logic [SEL_W-1:0]     out_rd_q;
    logic                 out_writes_rd_q;
    logic [DATA_W-1:0]    out_op1_q, out_op2_q, out_imm_q;
    logic                 stall, issue;
    logic [DATA_W-1:0]    op1, op2, imm_ext;

    localparam logic [REG_COUNT-1:0] ONE = {{(REG_COUNT-1){1'b0}}, 1'b1};

    // A writeback landing this cycle retires the pending write, so it no longer blocks issue.
    assign wb_hit   = wb_en ? (ONE << wb_select) : '0;
    assign eff_busy = busy_q & ~wb_hit;

    assign stall = (uses_rs1  && eff_busy[rs1]) ||
                   (uses_rs2  && eff_busy[rs2]) ||
                   (writes_rd && eff_busy[rd]);

    assign in_ready = reset & ~flush & ~stall & (~out_valid_q | out_ready);
    assign issue    = in_valid & in_ready;

    assign op1     = (wb_en && wb_select == rs1) ? wb_data : rf_read1;
    assign op2     = (wb_en && wb_select == rs2) ? wb_data : rf_read2;
    assign imm_ext = {{(DATA_W-8){imm8[7]}}, imm8};

    // A squashed entry never reaches writeback, so its busy bit must be released here.
    assign flush_clr = (flush && out_valid_q && out_writes_rd_q) ? (ONE << out_rd_q) : '0;
    assign issue_set = (issue && writes_rd) ? (ONE << rd) : '0;

    always_comb begin
        busy_d = (busy_q & ~wb_hit & ~flush_clr) | issue_set;

        out_valid_d = out_valid_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (issue)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q          <= '0;
            out_valid_q     <= 1'b0;
            out_opcode_q    <= '0;
            out_rd_q        <= '0;
            out_writes_rd_q <= 1'b0;
            out_op1_q       <= '0;
            out_op2_q       <= '0;
            out_imm_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            if (issue) begin
                out_opcode_q    <= opcode;
                out_rd_q        <= rd;
                out_writes_rd_q <= writes_rd;
                out_op1_q       <= op1;
                out_op2_q       <= op2;
                out_imm_q       <= imm_ext;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_opcode    = out_opcode_q;
    assign out_rd        = out_rd_q;
    assign out_writes_rd = out_writes_rd_q;
    assign out_op1       = out_op1_q;
    assign out_op2       = out_op2_q;
    assign out_imm       = out_imm_q;
    assign busy_mask     = busy_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: scoreboard queue of expected ID/EX entries plus
// direct checks on handshake, scoreboard mask and reset behaviour.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_instr;
    logic [3:0]  rf_r1_select, rf_r2_select;
    logic [19:0] rf_read1, rf_read2;
    logic        wb_en;
    logic [3:0]  wb_select;
    logic [19:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [3:0]  out_rd;
    logic        out_writes_rd;
    logic [19:0] out_op1, out_op2, out_imm;
    logic [15:0] busy_mask;

    always #5 clk = ~clk;

    logic [19:0] rf [16];
    assign rf_read1 = rf[rf_r1_select];
    assign rf_read2 = rf[rf_r2_select];

    operand_fetch_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_r1_select(rf_r1_select), .rf_r2_select(rf_r2_select),
        .rf_read1(rf_read1), .rf_read2(rf_read2),
        .wb_en(wb_en), .wb_select(wb_select), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_writes_rd(out_writes_rd),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .busy_mask(busy_mask)
    );

    typedef struct packed {
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic        wr;
        logic [19:0] op1;
        logic [19:0] op2;
        logic [19:0] imm;
    } exp_t;

    exp_t expq [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] opc, input logic [3:0] rd, input logic wr,
                        input logic [19:0] op1, input logic [19:0] op2, input logic [19:0] imm);
        exp_t e;
        e = '{opc: opc, rd: rd, wr: wr, op1: op1, op2: op2, imm: imm};
        expq.push_back(e);
    endtask

    // The register-file write happens on the same edge the writeback is presented.
    task automatic tick();
        @(posedge clk);
        if (wb_en) rf[wb_select] = wb_data;
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Monitor: an entry is retired when consumed or squashed.
    always @(negedge clk) begin
        if (reset && out_valid && (out_ready || flush)) begin
            exp_t act;
            exp_t e;
            act = '{opc: out_opcode, rd: out_rd, wr: out_writes_rd,
                    op1: out_op1, op2: out_op2, imm: out_imm};
            n_vec++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL entry: unexpected output 0x%0h at %0t", act, $time);
            end else begin
                e = expq.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL entry: got 0x%0h expected 0x%0h at %0t", act, e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        rf[1] = 20'd1234;
        rf[2] = 20'd12345;
        reset = 1'b0; in_valid = 1'b0; in_instr = '0; wb_en = 1'b0; wb_select = '0;
        wb_data = '0; flush = 1'b0; out_ready = 1'b0;

        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy_mask), 32'd0);
        chk("rst_op1", 32'(out_op1), 32'd0);
        tick(); tick();
        reset = 1'b1; settle();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // I1: opcode 0, rd 3, rs1 1, rs2 2
        in_valid = 1'b1; in_instr = 20'h03120; settle();
        chk("i1_in_ready", 32'(in_ready), 32'd1);
        push(4'h0, 4'h3, 1'b1, 20'd1234, 20'd12345, 20'h00020);
        tick();
        in_valid = 1'b0;
        chk("i1_out_valid", 32'(out_valid), 32'd1);
        chk("i1_busy", 32'(busy_mask), 32'h0008);
        chk("i1_writes_rd", 32'(out_writes_rd), 32'd1);
        chk("i1_op1", 32'(out_op1), 32'd1234);
        chk("i1_op2", 32'(out_op2), 32'd12345);

        // I2 reads r3 while busy: stalled until the writeback arrives, then bypassed
        in_valid = 1'b1; in_instr = 20'h14320; out_ready = 1'b1; settle();
        chk("raw_stall0", 32'(in_ready), 32'd0);
        tick(); settle();
        chk("raw_out_drained", 32'(out_valid), 32'd0);
        chk("raw_stall1", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b1; wb_select = 4'd3; wb_data = 20'd111; settle();
        chk("wb_unstall", 32'(in_ready), 32'd1);
        push(4'h1, 4'h4, 1'b1, 20'd111, 20'd12345, 20'h00020);
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("i2_busy", 32'(busy_mask), 32'h0010);
        tick();

        // Opcode C, imm8 F0: no rd write, sign-extended immediate; writeback releases r4
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 20'hC51F0;
        wb_en = 1'b1; wb_select = 4'd4; wb_data = 20'd99; settle();
        chk("c_in_ready", 32'(in_ready), 32'd1);
        push(4'hC, 4'h5, 1'b0, 20'd1234, 20'd0, 20'hFFFF0);
        tick();
        wb_en = 1'b0;
        chk("c_busy", 32'(busy_mask), 32'h0000);
        chk("c_imm", 32'(out_imm), 32'h000FFFF0);
        chk("c_writes_rd", 32'(out_writes_rd), 32'd0);

        // Backpressure for 3 cycles, then consume and issue on the same edge
        in_valid = 1'b1; in_instr = 20'h25410;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_imm", 32'(out_imm), 32'h000FFFF0);
            chk("hold_op1", 32'(out_op1), 32'd1234);
            tick();
        end
        out_ready = 1'b1; settle();
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        push(4'h2, 4'h5, 1'b1, 20'd99, 20'd1234, 20'h00010);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        chk("b2b_busy", 32'(busy_mask), 32'h0020);
        chk("b2b_rd", 32'(out_rd), 32'd5);

        // Flush the r5 entry: its busy bit is released and nothing issues
        flush = 1'b1; in_valid = 1'b1; in_instr = 20'h37120; settle();
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy_mask), 32'h0000);
        settle();
        chk("post_flush_ready", 32'(in_ready), 32'd1);
        push(4'h3, 4'h7, 1'b1, 20'd1234, 20'd12345, 20'h00020);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("i5_busy", 32'(busy_mask), 32'h0080);

        // Writeback to a register that is not busy leaves the mask alone
        wb_en = 1'b1; wb_select = 4'd9; wb_data = 20'd5;
        tick();
        wb_en = 1'b0;
        chk("wb_idle_busy", 32'(busy_mask), 32'h0080);
        chk("wb_idle_valid", 32'(out_valid), 32'd0);

        // Set and clear of r7 on the same edge: set wins; rs1=r7 takes the bypass
        in_valid = 1'b1; in_instr = 20'h47710;
        wb_en = 1'b1; wb_select = 4'd7; wb_data = 20'd555; settle();
        chk("setwin_ready", 32'(in_ready), 32'd1);
        push(4'h4, 4'h7, 1'b1, 20'd555, 20'd1234, 20'h00010);
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("setwin_busy", 32'(busy_mask), 32'h0080);
        tick();

        // Build out_valid=1 with busy_mask=0x0006, then reset mid-stream
        out_ready = 1'b0;
        wb_en = 1'b1; wb_select = 4'd7; wb_data = 20'd0;
        in_valid = 1'b1; in_instr = 20'h01340; settle();
        chk("r1_ready", 32'(in_ready), 32'd1);
        push(4'h0, 4'h1, 1'b1, 20'd111, 20'd99, 20'h00040);
        tick();
        wb_en = 1'b0; in_instr = 20'h02340; out_ready = 1'b1; settle();
        chk("r2_ready", 32'(in_ready), 32'd1);
        push(4'h0, 4'h2, 1'b1, 20'd111, 20'd99, 20'h00040);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre_rst_busy", 32'(busy_mask), 32'h0006);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy_mask), 32'h0000);
        chk("mid_rst_op1", 32'(out_op1), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        expq.delete();
        tick();
        reset = 1'b1; settle();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        tick(); tick();
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
